// File: rtl/fw_in_pack.sv
// fw_in_pack: packs LANES consecutive W-bit distance entries into one beat, buffers beats
// in a small FIFO and issues them to the fw core under inhibit back-pressure with block framing.
module fw_in_pack #(
  parameter int W               = 16,
  parameter int LANES           = 4,
  parameter int BEATS_PER_BLOCK = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [W-1:0]                  s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          inhibit,
  output logic [W*LANES-1:0]            fw_in,
  output logic                          in_valid,
  output logic                          block_done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int LW = $clog2(LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BEATS_PER_BLOCK);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_BLOCK - 1);

  logic [LW-1:0]        lane_q, lane_d;
  logic [W-1:0]         slot_q [LANES-1];
  logic [W*LANES-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [W*LANES-1:0]   fw_in_q, beat;
  logic                 in_valid_q, block_done_q;
  logic                 last, acc, push, pop;

  assign last       = lane_q == LAST_LANE;
  assign level      = wr_q - rd_q;
  assign s_ready    = !(last && level == FULL);
  assign acc        = s_valid && s_ready;
  assign push       = acc && last;
  assign pop        = !inhibit && level != '0;
  assign fw_in      = fw_in_q;
  assign in_valid   = in_valid_q;
  assign block_done = block_done_q;

  // slot 0 is the first entry of a beat and lands in the MSBs
  always_comb begin
    beat = '0;
    for (int i = 0; i < LANES - 1; i++) beat[(LANES-1-i)*W +: W] = slot_q[i];
    beat[W-1:0] = s_data;
    lane_d      = acc ? (last ? '0 : lane_q + 1'b1) : lane_q;
    wr_d        = wr_q + (AW + 1)'(push);
    rd_d        = rd_q + (AW + 1)'(pop);
    beat_cnt_d  = pop ? (beat_cnt_q == LAST_BEAT ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= beat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q       <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      beat_cnt_q   <= '0;
      fw_in_q      <= '0;
      in_valid_q   <= 1'b0;
      block_done_q <= 1'b0;
      for (int i = 0; i < LANES - 1; i++) slot_q[i] <= '0;
    end else begin
      lane_q       <= lane_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      beat_cnt_q   <= beat_cnt_d;
      in_valid_q   <= pop;
      block_done_q <= pop && beat_cnt_q == LAST_BEAT;
      if (pop) fw_in_q <= mem_q[rd_q[AW-1:0]];
      if (acc && !last) slot_q[lane_q] <= s_data;
    end
  end
endmodule

// File: tb/tb_fw_in_pack.sv
// tb_fw_in_pack: table vectors and a scoreboard of expected beats checked against fw_in_pack.
module tb_fw_in_pack;
  logic        clk = 1'b0, reset = 1'b1, s_valid = 1'b0, inhibit = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, in_valid, block_done;
  logic [63:0] fw_in;
  logic [2:0]  level;

  fw_in_pack dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .inhibit(inhibit), .fw_in(fw_in), .in_valid(in_valid), .block_done(block_done), .level(level)
  );

  always #5 clk = ~clk;

  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {logic [63:0] beat; int cyc; bit lat;} exp_t;
  typedef struct {logic [15:0] e0, e1, e2, e3; logic [63:0] exp;} vec_t;
  exp_t sb[$];
  vec_t tab[6];

  int cyc = 0;
  logic inh_s = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    inh_s <= inhibit;
  end

  int          m_lane = 0, beat_idx = 0, bd_cnt = 0;
  logic [15:0] m_slot [3];
  bit          use_tab = 0, lat_on = 0;
  logic [63:0] tab_exp = '0;

  always @(negedge clk) begin
    if (reset) begin
      chk("inhibit_gap", {63'b0, in_valid && inh_s}, 64'd0);
      if (in_valid) begin
        if (sb.size() == 0) begin
          tot_n++;
          $display("FAIL unexpected_beat: got %h expected none", fw_in);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat", fw_in, e.beat);
          if (e.lat) chk("latency", 64'(cyc), 64'(e.cyc));
        end
        chk("block_done", {63'b0, block_done}, {63'b0, beat_idx % 32 == 31});
        beat_idx++;
        if (block_done) bd_cnt++;
      end else chk("block_done_idle", {63'b0, block_done}, 64'd0);
    end
  end

  task automatic send(input logic [15:0] d);
    int t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      tot_n++;
      $display("FAIL send_timeout: entry %h not accepted", d);
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (m_lane < 3) begin
        m_slot[m_lane] = d;
        m_lane++;
      end else begin
        sb.push_back('{use_tab ? tab_exp : {m_slot[0], m_slot[1], m_slot[2], d}, cyc + 1, lat_on});
        m_lane = 0;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    m_lane   = 0;
    beat_idx = 0;
    sb.delete();
  endtask

  int bd0;
  bit done6;

  initial begin
    tab[0] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 64'h0000_0001_0002_0003};
    tab[1] = '{16'h0004, 16'h0005, 16'h0006, 16'h0007, 64'h0004_0005_0006_0007};
    tab[2] = '{16'h0008, 16'h0009, 16'h000A, 16'h000B, 64'h0008_0009_000A_000B};
    tab[3] = '{16'h000C, 16'h000D, 16'h000E, 16'h000F, 64'h000C_000D_000E_000F};
    tab[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 64'hFFFF_0000_FFFF_0000};
    tab[5] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'h1234_5678_9ABC_DEF0};
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_valid", {63'b0, in_valid}, 64'd0);
    chk("rst_fw_in", fw_in, 64'd0);
    chk("rst_block_done", {63'b0, block_done}, 64'd0);
    chk("rst_level", {61'b0, level}, 64'd0);
    chk("rst_s_ready", {63'b0, s_ready}, 64'd1);

    use_tab = 1;
    lat_on  = 1;
    for (int i = 0; i < 6; i++) begin
      tab_exp = tab[i].exp;
      send(tab[i].e0);
      send(tab[i].e1);
      send(tab[i].e2);
      send(tab[i].e3);
    end
    use_tab = 0;
    lat_on  = 0;
    drain("drain_pack");

    inhibit = 1'b1;
    for (int i = 0; i < 19; i++) send(16'h0100 + 16'(i));
    s_data  = 16'h0113;
    s_valid = 1'b1;
    #1;
    chk("bp_level", {61'b0, level}, 64'd4);
    chk("bp_s_ready", {63'b0, s_ready}, 64'd0);
    @(negedge clk);
    chk("bp_hold_level", {61'b0, level}, 64'd4);
    inhibit = 1'b0;
    fork
      send(16'h0113);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_burst", {63'b0, in_valid}, 64'd1);
      end
    join
    drain("drain_bp");

    do_reset();
    bd0 = bd_cnt;
    for (int i = 0; i < 256; i++) send(16'($urandom));
    drain("drain_block");
    chk("block_pulses", 64'(bd_cnt - bd0), 64'd2);

    send(16'h0055);
    send(16'h0066);
    do_reset();
    chk("mid_rst_level", {61'b0, level}, 64'd0);
    use_tab = 1;
    tab_exp = 64'h000A_000B_000C_000D;
    send(16'h000A);
    send(16'h000B);
    send(16'h000C);
    send(16'h000D);
    use_tab = 0;
    bd0 = bd_cnt;
    for (int i = 0; i < 120; i++) send(16'($urandom));
    drain("drain_rst_31");
    chk("rst_no_pulse_31", 64'(bd_cnt - bd0), 64'd0);
    for (int i = 0; i < 4; i++) send(16'($urandom));
    drain("drain_rst_32");
    chk("rst_pulse_32", 64'(bd_cnt - bd0), 64'd1);

    done6 = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) send(16'($urandom));
        done6 = 1;
      end
      while (!done6) begin
        @(negedge clk);
        inhibit = ~inhibit;
      end
    join
    inhibit = 1'b0;
    drain("drain_toggle");
    chk("end_level", {61'b0, level}, 64'd0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
